frame_stream_arbiter: RTL and testbench
=======================================

Name: frame_stream_arbiter

Overview:
- Shares one downstream zoom/pixel pipeline input between two pixel-stream sources (S0, S1), each a valid/ready feeder that emits whole frames.
- Grants are frame-granular. A source keeps ownership for exactly IMG_WIDTH*IMG_HEIGHT accepted beats, then ownership is re-arbitrated round-robin.
- Sits between the test-pattern/capture feeders and the zoom engine.
- Frames are never interleaved.

Parameters:
- IMG_WIDTH, 4, pixels per line.
- IMG_HEIGHT, 4, lines per frame. Frame length FRAME_PIXELS = IMG_WIDTH*IMG_HEIGHT.
- FCNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- s0_pixel_in  in  8  S0 pixel data.
- s0_valid_in  in  1  S0 valid.
- s0_ready_out  out  1  ready back to S0.
- s1_pixel_in  in  8  S1 pixel data.
- s1_valid_in  in  1  S1 valid.
- s1_ready_out  out  1  ready back to S1.
- pixel_out  out  8  muxed pixel to downstream.
- pixel_valid_out  out  1  downstream valid.
- pixel_ready_in  in  1  downstream ready.
- owner_out  out  1  current/last granted source (0=S0, 1=S1).
- busy_out  out  1  a grant is active.
- frame_start_out  out  1  current handshake is beat 0 of a frame.
- frame_end_out  out  1  current handshake is beat FRAME_PIXELS-1.
- frame_count_out  out  FCNT_W  completed frames (both sources), wraps modulo 2^FCNT_W.

Behaviour:
- Reset is asynchronous, active-low, and takes effect immediately, including mid-frame. While rst=0 and after release:
  - state=IDLE, beat counter=0, last_owner=1 (so S0 wins the first tie), frame_count_out=0, owner_out=1.
  - All ready outputs and all output strobes are 0; pixel_out=0.
  - A frame in progress is abandoned; no partial-frame completion is signalled.
- Handshake: a beat is accepted on a rising edge where the granted source's valid and pixel_ready_in are both 1 ("hs").
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE:
  - s0/s1 ready=0, pixel_valid_out=0, pixel_out=0, busy_out=0.
  - Next state:
    - Only one valid high: go to that source's GRANT state.
    - Both valid: grant the source != last_owner.
    - Neither: stay in IDLE.
  - Grant latency: one cycle from valid seen in IDLE to the grant; no beat is accepted in IDLE.
- GRANTx (combinational pass-through, zero added latency):
  - pixel_out = sx_pixel_in; pixel_valid_out = sx_valid_in; sx_ready_out = pixel_ready_in.
  - The non-granted source's ready=0.
  - busy_out=1; owner_out=x.
- Beat counter (width clog2(FRAME_PIXELS)+1) increments on each hs.
  - On hs with counter = FRAME_PIXELS-1: counter←0, last_owner←x, frame_count_out←+1 (wrapping), state←IDLE.
- Strobes:
  - frame_start_out = hs & (counter==0).
  - frame_end_out = hs & (counter==FRAME_PIXELS-1).
  - Both are combinational and coincide with the accepted beat. When FRAME_PIXELS=1 both assert on the same beat.
- No preemption: if the owner drops valid mid-frame, the grant holds indefinitely and the other source waits, even with its valid high.
- Downstream backpressure (pixel_ready_in=0) stalls the owner; counter holds.
- Minimum one IDLE cycle between consecutive frames. Back-to-back frames from the same source are allowed when it is the only requester.
- owner_out in IDLE shows last_owner.

Test Plan:
- Reset release with only S0 valid, ready_in=1 constant, FRAME_PIXELS=16:
  - grant on cycle 1; 16 beats pass with S0 data unchanged.
  - frame_start_out on beat 0, frame_end_out on beat 15, frame_count_out=1.
  - One IDLE cycle, then re-grant to S0.
- S0 and S1 both valid continuously from reset:
  - frames alternate S0, S1, S0, S1; owner_out follows.
  - s1_ready_out=0 throughout every S0 frame.
  - frame_count_out=4 after 4×(16+1) cycles.
- During an S0 frame, drop s0_valid_in for 5 cycles at beat 7 while s1_valid_in=1:
  - grant stays S0 and counter holds at 7.
  - frame completes at 16 beats before S1 is granted.
- Toggle pixel_ready_in 1/0 every cycle during an S1 frame:
  - exactly 16 hs; no duplicated or dropped pixels; data matches the S1 sequence 0x00..0x0F.
- Assert rst=0 asynchronously (between clock edges) at beat 9 of an S1 frame:
  - all ready outputs go to 0 immediately and the counter clears.
  - after release with both sources valid, S0 is granted first (last_owner reset to 1); frame_count_out=0.
- Run 256 frames with FCNT_W=8 → frame_count_out wraps to 0 on the 256th frame_end_out.

Source files
------------

// File: rtl/frame_stream_arbiter.sv
// Frame-granular round-robin arbiter that shares one downstream pixel stream between two
// valid/ready sources. Ownership is held for one whole frame at a time.
module frame_stream_arbiter #(
   parameter int IMG_WIDTH  = 4,
   parameter int IMG_HEIGHT = 4,
   parameter int FCNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        s0_pixel_in,
   input  logic              s0_valid_in,
   output logic              s0_ready_out,
   input  logic [7:0]        s1_pixel_in,
   input  logic              s1_valid_in,
   output logic              s1_ready_out,
   output logic [7:0]        pixel_out,
   output logic              pixel_valid_out,
   input  logic              pixel_ready_in,
   output logic              owner_out,
   output logic              busy_out,
   output logic              frame_start_out,
   output logic              frame_end_out,
   output logic [FCNT_W-1:0] frame_count_out
);

   localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
   localparam int CNT_W        = $clog2(FRAME_PIXELS) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_PIXELS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  beat_cnt;
   logic              last_owner;
   logic [FCNT_W-1:0] frame_cnt;
   logic              hs;
   logic              last_beat;

   assign last_beat       = (beat_cnt == LAST_BEAT);
   assign frame_count_out = frame_cnt;

   always_comb begin
      state_nxt       = state;
      s0_ready_out    = 1'b0;
      s1_ready_out    = 1'b0;
      pixel_out       = '0;
      pixel_valid_out = 1'b0;
      busy_out        = 1'b0;
      owner_out       = last_owner;
      hs              = 1'b0;
      unique case (state)
         IDLE: begin
            // On a tie the source that did not own the previous frame wins.
            if (s0_valid_in && s1_valid_in) begin
               state_nxt = last_owner ? GRANT0 : GRANT1;
            end else if (s0_valid_in) begin
               state_nxt = GRANT0;
            end else if (s1_valid_in) begin
               state_nxt = GRANT1;
            end
         end
         GRANT0: begin
            pixel_out       = s0_pixel_in;
            pixel_valid_out = s0_valid_in;
            s0_ready_out    = pixel_ready_in;
            busy_out        = 1'b1;
            owner_out       = 1'b0;
            hs              = s0_valid_in && pixel_ready_in;
            if (hs && last_beat) begin
               state_nxt = IDLE;
            end
         end
         GRANT1: begin
            pixel_out       = s1_pixel_in;
            pixel_valid_out = s1_valid_in;
            s1_ready_out    = pixel_ready_in;
            busy_out        = 1'b1;
            owner_out       = 1'b1;
            hs              = s1_valid_in && pixel_ready_in;
            if (hs && last_beat) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign frame_start_out = hs && (beat_cnt == '0);
   assign frame_end_out   = hs && last_beat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         beat_cnt   <= '0;
         last_owner <= 1'b1;
         frame_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (hs) begin
            if (last_beat) begin
               beat_cnt   <= '0;
               last_owner <= (state == GRANT1);
               frame_cnt  <= frame_cnt + 1'b1;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Scoreboard bench for frame_stream_arbiter: tests queue expected beats, a forked monitor
// pops one entry per downstream handshake and compares it.
module tb_frame_stream_arbiter;

   localparam int FP = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s0_pixel_in, s1_pixel_in;
   logic       s0_valid_in, s1_valid_in;
   logic       s0_ready_out, s1_ready_out;
   logic [7:0] pixel_out;
   logic       pixel_valid_out;
   logic       pixel_ready_in;
   logic       owner_out, busy_out, frame_start_out, frame_end_out;
   logic [7:0] frame_count_out;

   frame_stream_arbiter #(
      .IMG_WIDTH (4),
      .IMG_HEIGHT(4),
      .FCNT_W    (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s0_pixel_in    (s0_pixel_in),
      .s0_valid_in    (s0_valid_in),
      .s0_ready_out   (s0_ready_out),
      .s1_pixel_in    (s1_pixel_in),
      .s1_valid_in    (s1_valid_in),
      .s1_ready_out   (s1_ready_out),
      .pixel_out      (pixel_out),
      .pixel_valid_out(pixel_valid_out),
      .pixel_ready_in (pixel_ready_in),
      .owner_out      (owner_out),
      .busy_out       (busy_out),
      .frame_start_out(frame_start_out),
      .frame_end_out  (frame_end_out),
      .frame_count_out(frame_count_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       owner;
      logic [7:0] data;
      logic       start;
      logic       fin;
      logic [7:0] fc;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   // source models: S0 emits 0x80+n, S1 emits n, n = beats accepted since reset
   logic [7:0] s0_cnt, s1_cnt;
   int         s0_left, s1_left;
   bit         s0_en, s1_en, rdy_toggle;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      s0_valid_in = s0_en && (s0_left > 0);
      s0_pixel_in = 8'h80 + s0_cnt;
      s1_valid_in = s1_en && (s1_left > 0);
      s1_pixel_in = s1_cnt;
   endtask

   task automatic step();
      bit t0, t1;
      @(negedge clk);
      t0 = s0_valid_in && s0_ready_out;
      t1 = s1_valid_in && s1_ready_out;
      @(posedge clk);
      #1;
      if (t0) begin s0_cnt++; s0_left--; end
      if (t1) begin s1_cnt++; s1_left--; end
      if (rdy_toggle) pixel_ready_in = ~pixel_ready_in;
      drive();
   endtask

   task automatic push_frame(input logic src, input logic [7:0] base, input logic [7:0] fc,
                             input int nbeats);
      for (int k = 0; k < nbeats; k++) begin
         beat_t b;
         b.owner = src;
         b.data  = base + 8'(k);
         b.start = (k == 0);
         b.fin   = (k == FP - 1);
         b.fc    = fc;
         exp_q.push_back(b);
      end
   endtask

   // asserts reset immediately, checks reset outputs, then releases between clock edges
   task automatic do_reset(input int l0, input int l1);
      rst = 1'b0;
      #1;
      chk("rst_ready", {s0_ready_out, s1_ready_out}, 0);
      chk("rst_strobes", {pixel_valid_out, busy_out, frame_start_out, frame_end_out}, 0);
      chk("rst_pixel", pixel_out, 0);
      chk("rst_owner", owner_out, 1);
      chk("rst_fcount", frame_count_out, 0);
      chk("leftover_expected", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      s0_cnt = '0; s1_cnt = '0;
      s0_left = l0; s1_left = l1;
      s0_en = 1'b1; s1_en = 1'b1;
      rdy_toggle = 1'b0;
      pixel_ready_in = 1'b1;
      drive();
      #2;
      rst = 1'b1;
   endtask

   task automatic monitor();
      beat_t e;
      forever begin
         @(negedge clk);
         if (pixel_valid_out && pixel_ready_in) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got pixel %0h owner %0d expected no beat at %0t",
                        pixel_out, owner_out, $time);
            end else begin
               e = exp_q.pop_front();
               chk("beat_owner", owner_out, e.owner);
               chk("beat_pixel", pixel_out, e.data);
               chk("beat_start", frame_start_out, e.start);
               chk("beat_end", frame_end_out, e.fin);
               chk("beat_fcount", frame_count_out, e.fc);
               chk("beat_busy", busy_out, 1);
            end
         end
         if (!busy_out) begin
            chk("idle_outputs", {s0_ready_out, s1_ready_out, pixel_valid_out,
                                 frame_start_out, frame_end_out}, 0);
         end else if (owner_out == 1'b0) begin
            chk("s1_ready_blocked", s1_ready_out, 0);
            chk("s0_ready_pass", s0_ready_out, pixel_ready_in);
         end else begin
            chk("s0_ready_blocked", s0_ready_out, 0);
            chk("s1_ready_pass", s1_ready_out, pixel_ready_in);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      s0_cnt = '0; s1_cnt = '0; s0_left = 0; s1_left = 0;
      s0_en = 1'b0; s1_en = 1'b0; rdy_toggle = 1'b0;
      pixel_ready_in = 1'b1;
      drive();
      fork
         monitor();
      join_none
      @(posedge clk);
      #1;

      // T1: only S0, two back-to-back frames
      do_reset(2 * FP, 0);
      push_frame(1'b0, 8'h80, 8'd0, FP);
      push_frame(1'b0, 8'h90, 8'd1, FP);
      step();
      chk("t1_grant_busy", busy_out, 1);
      chk("t1_grant_owner", owner_out, 0);
      repeat (16) step();
      chk("t1_idle_gap", busy_out, 0);
      chk("t1_fcount1", frame_count_out, 1);
      chk("t1_idle_owner", owner_out, 0);
      repeat (17 + 5) step();
      chk("t1_fcount2", frame_count_out, 2);

      // T2: both sources always valid, strict alternation starting with S0
      do_reset(2 * FP, 2 * FP);
      push_frame(1'b0, 8'h80, 8'd0, FP);
      push_frame(1'b1, 8'h00, 8'd1, FP);
      push_frame(1'b0, 8'h90, 8'd2, FP);
      push_frame(1'b1, 8'h10, 8'd3, FP);
      repeat (4 * 17) step();
      chk("t2_fcount4", frame_count_out, 4);
      chk("t2_idle", busy_out, 0);
      repeat (3) step();

      // T3: S0 drops valid for 5 cycles at beat 7; S1 must keep waiting
      do_reset(FP, FP);
      push_frame(1'b0, 8'h80, 8'd0, FP);
      push_frame(1'b1, 8'h00, 8'd1, FP);
      repeat (8) step();
      s0_en = 1'b0;
      drive();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_hold_busy", busy_out, 1);
         chk("t3_hold_owner", owner_out, 0);
         chk("t3_s1_waits", s1_ready_out, 0);
      end
      s0_en = 1'b1;
      drive();
      repeat (30) step();
      chk("t3_fcount2", frame_count_out, 2);

      // T4: downstream ready toggles every cycle during an S1 frame
      do_reset(0, FP);
      push_frame(1'b1, 8'h00, 8'd0, FP);
      rdy_toggle = 1'b1;
      repeat (40) step();
      chk("t4_fcount1", frame_count_out, 1);
      chk("t4_idle", busy_out, 0);

      // T5: async reset at beat 9 of an S1 frame, after a completed S0 frame
      do_reset(FP, FP);
      push_frame(1'b0, 8'h80, 8'd0, FP);
      push_frame(1'b1, 8'h00, 8'd1, 9);
      repeat (17 + 1 + 9) step();
      chk("t5_pre_owner", owner_out, 1);
      chk("t5_pre_ready", s1_ready_out, 1);
      chk("t5_pre_fcount", frame_count_out, 1);
      #1;
      do_reset(FP, FP);
      push_frame(1'b0, 8'h80, 8'd0, FP);
      push_frame(1'b1, 8'h00, 8'd1, FP);
      step();
      chk("t5_first_grant", owner_out, 0);
      repeat (33 + 3) step();
      chk("t5_fcount2", frame_count_out, 2);

      // T6: 256 frames wrap the 8-bit frame counter back to 0
      do_reset(256 * FP, 0);
      for (int f = 0; f < 256; f++) begin
         push_frame(1'b0, 8'(8'h80 + 16 * f), 8'(f), FP);
      end
      repeat (256 * 17 + 3) step();
      chk("t6_fcount_wrap", frame_count_out, 0);
      chk("t6_done", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
